// File: rtl/fft_seq.sv
// Address/control sequencer for an in-place radix-2 DIF FFT over a single-port-pair data memory.
// Optional macro FFT_SEQ_STAGE_DRAIN_EN inserts a write-drain gap between stages.
module fft_seq #(
    parameter int LOG2N  = 6,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_rd_en,
    output logic [LOG2N-1:0] o_rd_addr1,
    output logic [LOG2N-1:0] o_rd_addr2,
    output logic [LOG2N-2:0] o_tw_addr,
    output logic             o_wr_en,
    output logic [LOG2N-1:0] o_wr_addr1,
    output logic [LOG2N-1:0] o_wr_addr2,
    output logic [3:0]       o_stage
);
    localparam int WR_DLY = RD_LAT + 1;
    localparam int KW     = LOG2N - 1;

    typedef enum logic [1:0] {IDLE, RUN, GAP, FLUSH} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_stg;
    logic [KW-1:0]    r_k;
    logic             r_busy;
    logic             r_rd_en;
    logic             r_rd_last;
    logic [LOG2N-1:0] r_rd_a1;
    logic [LOG2N-1:0] r_rd_a2;
    logic [KW-1:0]    r_tw;
    logic [3:0]       r_stage_o;
    logic [WR_DLY-1:0] r_pv;
    logic [WR_DLY-1:0] r_pl;
    logic [LOG2N-1:0] r_pa1 [WR_DLY];
    logic [LOG2N-1:0] r_pa2 [WR_DLY];

    logic [LOG2N-1:0] w_half;
    logic [LOG2N-1:0] w_mask;
    logic [LOG2N-1:0] w_kx;
    logic [LOG2N-1:0] w_j;
    logic [LOG2N-1:0] w_a1;
    logic [KW-1:0]    w_tw;
    logic             w_k_last;
    logic             w_s_last;
    logic             w_issue;
    logic             w_gap_done;

    // Butterfly operand addressing: half is a power of two, so g/j split is a mask.
    always_comb begin
        w_half   = LOG2N'(1) << (4'(LOG2N - 1) - r_stg);
        w_mask   = w_half - LOG2N'(1);
        w_kx     = {1'b0, r_k};
        w_j      = w_kx & w_mask;
        w_a1     = ((w_kx & ~w_mask) << 1) | w_j;
        w_tw     = KW'(w_j << r_stg);
        w_k_last = (r_k == {KW{1'b1}});
        w_s_last = (r_stg == 4'(LOG2N - 1));
    end

`ifdef FFT_SEQ_STAGE_DRAIN_EN
    localparam int GW = $clog2(WR_DLY + 1);
    logic [GW-1:0] r_gap;

    // Counts idle cycles spent waiting for the previous stage's writes to land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap <= '0;
        end else if (r_state == GAP && !w_gap_done) begin
            r_gap <= r_gap + GW'(1);
        end else begin
            r_gap <= '0;
        end
    end

    assign w_gap_done = (r_gap == GW'(WR_DLY - 1));
`else
    assign w_gap_done = 1'b1;
`endif

    // Next-state and issue decision; a read is issued in the very cycle start is accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = RUN;
                    w_issue     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                w_issue = 1'b1;
                if (w_k_last && w_s_last) begin
                    w_state_nxt = FLUSH;
                end else if (w_k_last) begin
`ifdef FFT_SEQ_STAGE_DRAIN_EN
                    w_state_nxt = GAP;
`else
                    w_state_nxt = RUN;
`endif
                end else begin
                    w_state_nxt = RUN;
                end
            end
            GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = GAP;
                end
            end
            FLUSH: begin
                if (r_pl[WR_DLY-1]) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = FLUSH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters, registered read port and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_stg     <= 4'd0;
            r_k       <= '0;
            r_busy    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_last <= 1'b0;
            r_rd_a1   <= '0;
            r_rd_a2   <= '0;
            r_tw      <= '0;
            r_stage_o <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_en   <= w_issue;
            r_rd_last <= w_issue && w_k_last && w_s_last;
            if (r_state == IDLE && i_start) begin
                r_busy <= 1'b1;
            end else if (r_pl[WR_DLY-2]) begin
                r_busy <= 1'b0;
            end
            if (w_issue) begin
                r_rd_a1   <= w_a1;
                r_rd_a2   <= w_a1 | w_half;
                r_tw      <= w_tw;
                r_stage_o <= r_stg;
                r_k       <= r_k + KW'(1);
                if (w_k_last) begin
                    r_stg <= w_s_last ? 4'd0 : r_stg + 4'd1;
                end
            end
        end
    end

    // Write-side delay line: read strobe/addresses shifted by memory latency plus butterfly register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            r_pl <= '0;
            for (int i = 0; i < WR_DLY; i++) begin
                r_pa1[i] <= '0;
                r_pa2[i] <= '0;
            end
        end else begin
            r_pv     <= {r_pv[WR_DLY-2:0], r_rd_en};
            r_pl     <= {r_pl[WR_DLY-2:0], r_rd_last};
            r_pa1[0] <= r_rd_a1;
            r_pa2[0] <= r_rd_a2;
            for (int i = 1; i < WR_DLY; i++) begin
                r_pa1[i] <= r_pa1[i-1];
                r_pa2[i] <= r_pa2[i-1];
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_pl[WR_DLY-1];
    assign o_rd_en    = r_rd_en;
    assign o_rd_addr1 = r_rd_a1;
    assign o_rd_addr2 = r_rd_a2;
    assign o_tw_addr  = r_tw;
    assign o_stage    = r_stage_o;
    assign o_wr_en    = r_pv[WR_DLY-1];
    assign o_wr_addr1 = r_pa1[WR_DLY-1];
    assign o_wr_addr2 = r_pa2[WR_DLY-1];

endmodule
